dcache_flush_unit: RTL

- Responder side of the controller's dcache flush handshake.
- On a flush request it walks every set of the write-back dcache, writes back each valid and dirty line through the miss unit, then invalidates all ways of that set.
- When the whole cache has been walked it pulses an acknowledge.
- Sits inside the write-back dcache, between the flush request/ack lines and the tag-array arbiter / miss-unit writeback port.

---
 rtl/dcache_flush_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_flush_unit.sv
// Dcache flush responder: on flush_i, walks every set, writes back each
// valid+dirty line via the miss unit, invalidates the set, then pulses ack.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   flush_i / flush_ack_o    flush request level / one-cycle completion pulse
//   busy_o                   high whenever the walker is not idle
//   tag_*                    tag-array read/invalidate port (req held until gnt)
//   wb_*                     miss-unit writeback port (req held until gnt)
module dcache_flush_unit #(
   parameter int NUM_SETS = 256,
   parameter int NUM_WAYS = 8,
   parameter int TAG_W    = 44,
   parameter int OFFSET_W = 4,
   parameter int IDX_W    = $clog2(NUM_SETS),
   parameter int WAY_W    = $clog2(NUM_WAYS),
   parameter int PLEN     = TAG_W + IDX_W + OFFSET_W
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   output logic                      flush_ack_o,
   output logic                      busy_o,
   output logic                      tag_req_o,
   input  logic                      tag_gnt_i,
   output logic                      tag_we_o,
   output logic [IDX_W-1:0]          tag_idx_o,
   output logic [NUM_WAYS-1:0]       tag_way_o,
   input  logic [NUM_WAYS-1:0]       tag_valid_i,
   input  logic [NUM_WAYS-1:0]       tag_dirty_i,
   input  logic [NUM_WAYS*TAG_W-1:0] tag_rdata_i,
   output logic                      wb_req_o,
   input  logic                      wb_gnt_i,
   output logic [PLEN-1:0]           wb_addr_o,
   output logic [WAY_W-1:0]          wb_way_o,
   input  logic                      wb_done_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_WB_REQ,
      S_WB_WAIT,
      S_INV,
      S_ACK,
      S_DRAIN
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [IDX_W-1:0]          r_idx;
   logic [IDX_W-1:0]          w_idx_nxt;
   logic [NUM_WAYS-1:0]       r_pend;
   logic [NUM_WAYS-1:0]       w_pend_nxt;
   logic [NUM_WAYS*TAG_W-1:0] r_tags;
   logic                      w_cap;
   logic [NUM_WAYS-1:0]       w_pend_cap;
   logic [NUM_WAYS-1:0]       w_pend_clr;
   logic [WAY_W-1:0]          w_way;
   logic [TAG_W-1:0]          w_tag;
   logic                      w_last;

   assign w_pend_cap = tag_valid_i & tag_dirty_i;
   assign w_last     = (r_idx == IDX_W'(NUM_SETS - 1));
   assign busy_o     = (r_state != S_IDLE);

   // Lowest pending way: scan downwards so the lowest index wins.
   // r_pend only changes when a writeback retires, so the pick stays
   // stable while a request waits for its grant.
   always_comb begin
      w_way      = '0;
      w_tag      = '0;
      w_pend_clr = r_pend;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_way      = WAY_W'(i);
            w_tag      = r_tags[i*TAG_W +: TAG_W];
            w_pend_clr = r_pend & ~(NUM_WAYS'(1) << i);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_pend  <= '0;
         r_tags  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_pend  <= w_pend_nxt;
         if (w_cap) begin
            r_tags <= tag_rdata_i;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_pend_nxt  = r_pend;
      w_cap       = 1'b0;
      flush_ack_o = 1'b0;
      tag_req_o   = 1'b0;
      tag_we_o    = 1'b0;
      tag_idx_o   = '0;
      tag_way_o   = '0;
      wb_req_o    = 1'b0;
      wb_addr_o   = '0;
      wb_way_o    = '0;
      unique case (r_state)
         S_IDLE: begin
            if (flush_i) begin
               w_state_nxt = S_READ;
               w_idx_nxt   = '0;
            end
         end
         S_READ: begin
            tag_req_o = 1'b1;
            tag_idx_o = r_idx;
            if (tag_gnt_i) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            w_cap       = 1'b1;
            w_pend_nxt  = w_pend_cap;
            w_state_nxt = (|w_pend_cap) ? S_WB_REQ : S_INV;
         end
         S_WB_REQ: begin
            wb_req_o  = 1'b1;
            wb_way_o  = w_way;
            wb_addr_o = {w_tag, r_idx, {OFFSET_W{1'b0}}};
            if (wb_gnt_i) begin
               // Done may arrive with the grant: retire it right here.
               if (wb_done_i) begin
                  w_pend_nxt  = w_pend_clr;
                  w_state_nxt = (|w_pend_clr) ? S_WB_REQ : S_INV;
               end else begin
                  w_state_nxt = S_WB_WAIT;
               end
            end
         end
         S_WB_WAIT: begin
            if (wb_done_i) begin
               w_pend_nxt  = w_pend_clr;
               w_state_nxt = (|w_pend_clr) ? S_WB_REQ : S_INV;
            end
         end
         S_INV: begin
            tag_req_o = 1'b1;
            tag_we_o  = 1'b1;
            tag_idx_o = r_idx;
            tag_way_o = '1;
            if (tag_gnt_i) begin
               if (w_last) begin
                  w_state_nxt = S_ACK;
               end else begin
                  w_idx_nxt   = r_idx + 1'b1;
                  w_state_nxt = S_READ;
               end
            end
         end
         S_ACK: begin
            flush_ack_o = 1'b1;
            w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // The registered request lingers after the ack; wait it out.
            if (!flush_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
